dfp_divider: RTL and testbench
==============================

Name: dfp_divider

Overview:
- Multi-cycle IEEE-754 double-precision divider: a / b, inverse operation of dfp_multiplier.
- Same split operand interface (sign, exponent, mantissa per operand) and the same 64-bit result plus 8-bit flags.
- Occupies one FP divide functional-unit slot in the Tomasulo datapath.
- Accepts one operation at a time via a valid/ready issue handshake, carries a reservation-station tag, and holds its result until the CDB grants it.

Parameters:
- TAG_W, 4, width of the reservation-station tag carried with each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  issue request
- in_ready  output  1  unit idle, can accept
- in_tag  input  TAG_W  tag of issued operation
- sa, sb  input  1  signs of a, b
- ea, eb  input  11  biased exponents
- ma, mb  input  52  fraction fields (hidden bit implicit)
- out_valid  output  1  result available
- out_ready  input  1  CDB grant
- out_tag  output  TAG_W  tag of completed operation
- res  output  64  result {sign, exp, fraction}
- flags  output  8  status, bit positions below

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - in_ready=1, out_valid=0, res=0, flags=0, out_tag=0.
  - An in-flight operation is discarded with no output.
- flags bits:
  - [0] invalid, [1] div-by-zero, [2] overflow, [3] underflow, [4] inexact
  - [5] result zero, [6] result inf, [7] result NaN
- Subnormal inputs (e=0, m≠0) are flushed to signed zero before classification.
- Result sign is sa^sb for every non-NaN result.
- State machine IDLE -> CHECK -> DIV -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - If in_valid=1, latch operands and tag; next state CHECK; in_ready drops the following cycle.
- CHECK (1 cycle): classify operands.
  - Either operand NaN, 0/0, or inf/inf: res=0x7FF8000000000000, flags[0] and [7] set.
  - finite/0, a nonzero: inf, flags[1] and [6] set.
  - inf/finite: inf, flags[6] set.
  - 0/nonzero or finite/inf: signed zero, flags[5] set.
  - All special cases go directly to DONE.
  - Normal operands: load remainder = {1,ma}, divisor = {1,mb}; exponent = ea - eb + 1023, computed as 13-bit signed. Next state DIV.
- DIV:
  - Radix-2 restoring division, one quotient bit per cycle, exactly 55 cycles.
  - Produces q[54:0], where q[54] is the integer bit.
  - Iteration counter is 6 bits.
- ROUND (1 cycle):
  - q[54]=1: mantissa=q[53:2], guard=q[1], round=q[0].
  - Otherwise: mantissa=q[52:1], guard=q[0], round=0, and exponent is decremented.
  - sticky = (remainder≠0).
  - Round-to-nearest-even. A mantissa carry-out increments the exponent.
  - inexact = guard|round|sticky.
  - exponent ≥2047: signed inf, flags[2],[4],[6] set.
  - exponent ≤0: signed zero, flags[3],[4],[5] set.
- DONE:
  - out_valid=1; res, flags and out_tag are held stable.
  - Leave to IDLE on a cycle with out_ready=1; out_valid is 0 the next cycle.
  - out_ready high while out_valid=0 is ignored.
- Latency, counted from the accepting edge to the first cycle with out_valid=1:
  - Special cases: 2 cycles.
  - Normal operations: 58 cycles.
- Throughput: one operation at a time. in_valid during busy is ignored and not queued.

Decomposition:
- Package dfp_pkg holds:
  - Flag bit index constants.
  - BIAS=1023, EXP_MAX=2047.
  - QNAN, POS_INF constants.
  - State encoding.
  - DIV_ITERS=55.
- Sub-module dfp_div_core holds the iterative mantissa divider:
  - Inputs: start, dividend, divisor.
  - Outputs: q[54:0], sticky, done.
  - Separates the radix-2 loop from the classification and rounding FSM.

Test Plan:
- 0x4008000000000000 / 0x3FF8000000000000 (3.0/1.5), out_ready=1 -> res=0x4000000000000000, flags=0x00, out_valid exactly 58 cycles after accept, tag echoed.
- 0x3FF0000000000000 / 0x4008000000000000 (1/3) -> res=0x3FD5555555555555, flags=0x10 (inexact).
- 1.0/+0 -> 0x7FF0000000000000, flags=0x42, latency 2. 0/0 -> 0x7FF8000000000000, flags=0x81.
- 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000, flags=0x54. 0x0010000000000000 / 0x4000000000000000 -> 0x0000000000000000, flags=0x38.
- Hold out_ready=0 for 10 cycles after completion -> out_valid, res and tag stable; second in_valid during busy ignored; accepted on the first cycle in_ready=1.
- Assert rst_n=0 at DIV iteration 20 -> all outputs zero and in_ready=1 immediately, no spurious out_valid; next operation 3.0/1.5 completes correctly.

Source files
------------

// File: rtl/dfp_pkg.sv
// Shared constants, state encoding and result bundle for the double-precision divider.
package dfp_pkg;

  localparam int F_INVALID   = 0;
  localparam int F_DIVZERO   = 1;
  localparam int F_OVERFLOW  = 2;
  localparam int F_UNDERFLOW = 3;
  localparam int F_INEXACT   = 4;
  localparam int F_ZERO      = 5;
  localparam int F_INF       = 6;
  localparam int F_NAN       = 7;

  localparam int BIAS      = 1023;
  localparam int EXP_MAX   = 2047;
  localparam int DIV_ITERS = 55;

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  flags;
  } result_t;

endpackage

// File: rtl/dfp_divider_if.sv
// Issue / completion handshake bundle between a reservation station, the divider and the CDB.
interface dfp_divider_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic             sa;
  logic             sb;
  logic [10:0]      ea;
  logic [10:0]      eb;
  logic [51:0]      ma;
  logic [51:0]      mb;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [63:0]      res;
  logic [7:0]       flags;

  modport master (
    output in_valid, in_tag, sa, sb, ea, eb, ma, mb, out_ready,
    input  in_ready, out_valid, out_tag, res, flags
  );

  modport slave (
    input  in_valid, in_tag, sa, sb, ea, eb, ma, mb, out_ready,
    output in_ready, out_valid, out_tag, res, flags
  );
endinterface

// File: rtl/dfp_div_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle, DIV_ITERS cycles per start.
module dfp_div_core
  import dfp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [52:0] dividend,
  input  logic [52:0] divisor,
  output logic [54:0] q,
  output logic        sticky,
  output logic        done
);
  // rem stays below 2*divisor, so one spare bit above the divisor width is enough
  logic [54:0] rem;
  logic [52:0] dvs;
  logic [55:0] diff;
  logic [54:0] rem_sel;
  logic [5:0]  cnt;
  logic        busy;
  logic        qbit;

  assign diff    = {1'b0, rem} - {3'b000, dvs};
  assign qbit    = ~diff[55];
  assign rem_sel = qbit ? diff[54:0] : rem;
  assign done    = busy && (cnt == 6'(DIV_ITERS - 1));
  assign sticky  = |rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 6'd1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem <= {2'b00, dividend};
      dvs <= divisor;
      q   <= '0;
    end else if (busy) begin
      rem <= rem_sel << 1;
      q   <= {q[53:0], qbit};
    end
  end

endmodule

// File: rtl/dfp_divider.sv
// Multi-cycle IEEE-754 double divider FU: classify, iterate, round to nearest even, hold for CDB.
module dfp_divider
  import dfp_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  dfp_divider_if.slave bus
);
  localparam logic signed [12:0] BIAS_S  = 13'(BIAS);
  localparam logic signed [12:0] EXP_LIM = 13'(EXP_MAX);

  state_t             state, state_nxt;
  logic               sa_r, sb_r, sign;
  logic [10:0]        ea_r, eb_r;
  logic [51:0]        ma_r, mb_r;
  logic [TAG_W-1:0]   tag_r, out_tag_r;
  logic signed [12:0] exp_r, exp_c;
  logic [63:0]        res_r;
  logic [7:0]         flags_r;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic               core_start, core_sticky, core_done;
  logic [54:0]        core_q;
  result_t            spec_out, rnd_out;

  function automatic result_t round_rne(input logic [54:0] qv, input logic stk,
                                        input logic signed [12:0] e_in, input logic sgn);
    result_t            o;
    logic [51:0]        mant;
    logic [52:0]        mr;
    logic               g, r, up;
    logic signed [12:0] e;
    if (qv[54]) begin
      mant = qv[53:2]; g = qv[1]; r = qv[0]; e = e_in;
    end else begin
      mant = qv[52:1]; g = qv[0]; r = 1'b0; e = e_in - 13'sd1;
    end
    up = g & (r | stk | mant[0]);
    mr = {1'b0, mant} + 53'(up);
    if (mr[52]) e = e + 13'sd1;
    o = '0;
    o.flags[F_INEXACT] = g | r | stk;
    if (e >= EXP_LIM) begin
      o.res = {sgn, POS_INF[62:0]};
      o.flags[F_OVERFLOW] = 1'b1; o.flags[F_INEXACT] = 1'b1; o.flags[F_INF] = 1'b1;
    end else if (e <= 13'sd0) begin
      o.res = {sgn, 63'd0};
      o.flags[F_UNDERFLOW] = 1'b1; o.flags[F_INEXACT] = 1'b1; o.flags[F_ZERO] = 1'b1;
    end else begin
      o.res = {sgn, e[10:0], mr[51:0]};
    end
    return o;
  endfunction

  dfp_div_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .dividend ({1'b1, ma_r}),
    .divisor  ({1'b1, mb_r}),
    .q        (core_q),
    .sticky   (core_sticky),
    .done     (core_done)
  );

  // subnormals are flushed: a zero exponent is treated as zero whatever the fraction
  assign sign   = sa_r ^ sb_r;
  assign a_zero = (ea_r == 11'd0);
  assign b_zero = (eb_r == 11'd0);
  assign a_inf  = (ea_r == 11'h7FF) && (ma_r == '0);
  assign b_inf  = (eb_r == 11'h7FF) && (mb_r == '0);
  assign a_nan  = (ea_r == 11'h7FF) && (ma_r != '0);
  assign b_nan  = (eb_r == 11'h7FF) && (mb_r != '0);
  assign exp_c  = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS_S;
  assign rnd_out = round_rne(core_q, core_sticky, exp_r, sign);

  always_comb begin
    spec_out = '0;
    special  = 1'b1;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_out.res = QNAN;
      spec_out.flags[F_INVALID] = 1'b1; spec_out.flags[F_NAN] = 1'b1;
    end else if (a_inf) begin
      spec_out.res = {sign, POS_INF[62:0]};
      spec_out.flags[F_INF] = 1'b1;
    end else if (b_zero) begin
      spec_out.res = {sign, POS_INF[62:0]};
      spec_out.flags[F_DIVZERO] = 1'b1; spec_out.flags[F_INF] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_out.res = {sign, 63'd0};
      spec_out.flags[F_ZERO] = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (special) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt  = S_DIV;
          core_start = 1'b1;
        end
      end
      S_DIV:   if (core_done) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.in_valid) begin
      sa_r  <= bus.sa;  sb_r <= bus.sb;
      ea_r  <= bus.ea;  eb_r <= bus.eb;
      ma_r  <= bus.ma;  mb_r <= bus.mb;
      tag_r <= bus.in_tag;
    end
    if (state == S_CHECK) exp_r <= exp_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r     <= '0;
      flags_r   <= '0;
      out_tag_r <= '0;
    end else if (state == S_CHECK && special) begin
      res_r     <= spec_out.res;
      flags_r   <= spec_out.flags;
      out_tag_r <= tag_r;
    end else if (state == S_ROUND) begin
      res_r     <= rnd_out.res;
      flags_r   <= rnd_out.flags;
      out_tag_r <= tag_r;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.res       = res_r;
  assign bus.flags     = flags_r;
  assign bus.out_tag   = out_tag_r;

endmodule

// File: tb/tb_dfp_divider.sv
// Directed bench for dfp_divider: hand-computed quotients, flags, latency, hold and reset behaviour.
module tb_dfp_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] V_3_0   = 64'h4008_0000_0000_0000;
  localparam logic [63:0] V_1_5   = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] V_1_0   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] V_2_0   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] V_PINF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] V_NINF  = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] V_QNAN  = 64'h7FF8_0000_0000_0000;

  dfp_divider_if #(.TAG_W(4)) bus ();

  dfp_divider #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic drive_ops(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    bus.sa = a[63]; bus.ea = a[62:52]; bus.ma = a[51:0];
    bus.sb = b[63]; bus.eb = b[62:52]; bus.mb = b[51:0];
    bus.in_tag = tag;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    int w = 0;
    drive_ops(a, b, tag);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    check_eq("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // lat0 is the number of edges already elapsed counting the accepting edge as 1.
  task automatic wait_result(input string name, input logic [63:0] want_res, input logic [7:0] want_flags,
                             input logic [3:0] want_tag, input int want_lat, input int lat0);
    int lat = lat0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({name, "_lat"},   64'(lat),         64'(want_lat));
    check_eq({name, "_res"},   bus.res,          want_res);
    check_eq({name, "_flags"}, 64'(bus.flags),   64'(want_flags));
    check_eq({name, "_tag"},   64'(bus.out_tag), 64'(want_tag));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check_eq({name, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                        input logic [63:0] want_res, input logic [7:0] want_flags, input int want_lat);
    issue(a, b, tag);
    wait_result(name, want_res, want_flags, tag, want_lat, 1);
  endtask

  initial begin
    logic stable;
    logic seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_ops(64'd0, 64'd0, 4'd0);
    #2;
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_res",       bus.res,            64'd0);
    check_eq("rst_flags",     64'(bus.flags),     64'd0);
    check_eq("rst_out_tag",   64'(bus.out_tag),   64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("div_3_by_1p5",  V_3_0, V_1_5, 4'd3, V_2_0,                  8'h00, 58);
    run_op("div_1_by_3",    V_1_0, V_3_0, 4'd4, 64'h3FD5_5555_5555_5555, 8'h10, 58);
    run_op("div_5_by_3_up", 64'h4014_0000_0000_0000, V_3_0, 4'd6,
                            64'h3FFA_AAAA_AAAA_AAAB, 8'h10, 58);
    run_op("div_neg6_by_2", 64'hC018_0000_0000_0000, V_2_0, 4'd2,
                            64'hC008_0000_0000_0000, 8'h00, 58);
    run_op("div_by_zero",   V_1_0, 64'd0, 4'd8, V_PINF, 8'h42, 2);
    run_op("neg_by_zero",   64'hBFF0_0000_0000_0000, 64'd0, 4'd1, V_NINF, 8'h42, 2);
    run_op("zero_by_zero",  64'd0, 64'd0, 4'd10, V_QNAN, 8'h81, 2);
    run_op("inf_by_inf",    V_PINF, V_PINF, 4'd11, V_QNAN, 8'h81, 2);
    run_op("nan_by_one",    64'h7FF0_0000_0000_0001, V_1_0, 4'd12, V_QNAN, 8'h81, 2);
    run_op("ninf_by_two",   V_NINF, V_2_0, 4'd13, V_NINF, 8'h40, 2);
    run_op("one_by_inf",    V_1_0, V_PINF, 4'd14, 64'd0, 8'h20, 2);
    run_op("subnorm_flush", 64'h0000_0000_0000_0001, V_1_0, 4'd15, 64'd0, 8'h20, 2);
    run_op("overflow",      64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 4'd5, V_PINF, 8'h54, 58);
    run_op("underflow",     64'h0010_0000_0000_0000, V_2_0, 4'd7, 64'd0, 8'h38, 58);

    // result held for the CDB while a second issue request waits
    bus.out_ready = 1'b0;
    issue(V_3_0, V_1_5, 4'd5);
    repeat (4) begin @(posedge clk); #1; end
    drive_ops(V_1_0, 64'd0, 4'd9);
    bus.in_valid = 1'b1;
    wait_result("hold_op", V_2_0, 8'h00, 4'd5, 58, 5);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(bus.out_valid && bus.res == V_2_0 && bus.out_tag == 4'd5 && !bus.in_ready)) stable = 1'b0;
    end
    check_eq("hold_stable", 64'(stable), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_valid_drop", 64'(bus.out_valid), 64'd0);
    check_eq("hold_idle_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk); #1;
    check_eq("waiting_issue_accepted", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_result("waiting_op", V_PINF, 8'h42, 4'd9, 2, 1);

    // reset in the middle of the iteration loop
    issue(V_3_0, V_1_5, 4'd6);
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_res",       bus.res,            64'd0);
    check_eq("midrst_flags",     64'(bus.flags),     64'd0);
    check_eq("midrst_out_tag",   64'(bus.out_tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check_eq("midrst_no_valid", 64'(seen), 64'd0);
    run_op("after_reset", V_3_0, V_1_5, 4'd3, V_2_0, 8'h00, 58);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
